// File: rtl/audio_out_mixer.sv
// audio_out_mixer: mixes two gated square-wave voices with optional codec
// input into saturated 32-bit stereo samples. Each sample takes one codec
// FIFO handshake: IDLE -> CAPTURE (pop) -> MIX -> WRITE (push).
//
// Ports:
//   CLOCK_50, reset            clock, synchronous active-high reset
//   title_snd, title_active    title voice phase / note-on
//   fx_snd, fx_active          effect voice phase / note-on
//   mic_enable, mute           add codec input / force silence
//   audio_in_available         codec input FIFO non-empty
//   audio_out_allowed          codec output FIFO has space
//   left/right_channel_audio_in   signed codec input samples
//   read_audio_in              pop strobe (CAPTURE cycle)
//   write_audio_out            push strobe (WRITE cycle with space)
//   left/right_channel_audio_out  signed mixed samples, held between MIXes
//   clip_flag                  sticky saturation indicator
//   sample_count               samples written, wraps at 16 bits
module audio_out_mixer #(
    parameter logic [31:0] AMP_TITLE = 32'd60000000,
    parameter logic [31:0] AMP_FX    = 32'd80000000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        title_snd,
    input  logic        title_active,
    input  logic        fx_snd,
    input  logic        fx_active,
    input  logic        mic_enable,
    input  logic        mute,
    input  logic        audio_in_available,
    input  logic        audio_out_allowed,
    input  logic [31:0] left_channel_audio_in,
    input  logic [31:0] right_channel_audio_in,
    output logic        read_audio_in,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic        clip_flag,
    output logic [15:0] sample_count
);

    localparam int unsigned SW = 32;  // sample width
    localparam int unsigned PW = 37;  // amplitude * gain product width
    localparam int unsigned MW = 34;  // mix accumulator width
    localparam int unsigned GW = 5;   // gain width
    localparam int unsigned CW = 16;  // sample counter width

    localparam logic [GW-1:0]        G_MAX   = 5'd16;
    localparam logic signed [MW-1:0] SUM_MAX = 34'sh0_7FFF_FFFF;
    localparam logic signed [MW-1:0] SUM_MIN = 34'sh3_8000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        MIX     = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_read;
    logic   w_write;

    logic signed [SW-1:0] r_left_in;
    logic signed [SW-1:0] r_right_in;
    logic                 r_title_snd;
    logic                 r_fx_snd;
    logic                 r_title_act;
    logic                 r_fx_act;
    logic                 r_mic;
    logic                 r_mute;
    logic [GW-1:0]        r_gt;
    logic [GW-1:0]        r_gf;
    logic [SW-1:0]        r_left_out;
    logic [SW-1:0]        r_right_out;
    logic                 r_clip;
    logic [CW-1:0]        r_cnt;

    logic [PW-1:0]        w_prod_t;
    logic [PW-1:0]        w_prod_f;
    logic [MW-1:0]        w_mag_t;
    logic [MW-1:0]        w_mag_f;
    logic signed [MW-1:0] w_term_t;
    logic signed [MW-1:0] w_term_f;
    logic signed [MW-1:0] w_mic_l;
    logic signed [MW-1:0] w_mic_r;
    logic signed [MW-1:0] w_sum_l;
    logic signed [MW-1:0] w_sum_r;
    logic                 w_ovf_l;
    logic                 w_ovf_r;

    // Clamp a mix sum to the 32-bit signed range.
    function automatic logic [SW-1:0] sat32(input logic signed [MW-1:0] s);
        if (s > SUM_MAX) begin
            return 32'h7FFF_FFFF;
        end else if (s < SUM_MIN) begin
            return 32'h8000_0000;
        end else begin
            return s[SW-1:0];
        end
    endfunction

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and FIFO strobes; strobes follow the registered state and
    // the live space flag so a push lands in the first cycle space returns.
    always_comb begin
        w_next  = r_state;
        w_read  = 1'b0;
        w_write = 1'b0;
        case (r_state)
            IDLE: begin
                if (audio_in_available && audio_out_allowed) begin
                    w_next = CAPTURE;
                end
            end
            CAPTURE: begin
                w_read = 1'b1;
                w_next = MIX;
            end
            MIX: begin
                w_next = WRITE;
            end
            WRITE: begin
                if (audio_out_allowed) begin
                    w_write = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (reset) begin
            w_read  = 1'b0;
            w_write = 1'b0;
        end
    end

    // Voice terms: floor(AMP * g / 16) with the gain before this sample's update.
    assign w_prod_t = PW'(AMP_TITLE) * PW'(r_gt);
    assign w_prod_f = PW'(AMP_FX) * PW'(r_gf);
    assign w_mag_t  = MW'(w_prod_t >> 4);
    assign w_mag_f  = MW'(w_prod_f >> 4);
    assign w_term_t = r_title_snd ? $signed(w_mag_t) : -$signed(w_mag_t);
    assign w_term_f = r_fx_snd    ? $signed(w_mag_f) : -$signed(w_mag_f);

    assign w_mic_l  = r_mic ? MW'(r_left_in)  : '0;
    assign w_mic_r  = r_mic ? MW'(r_right_in) : '0;
    assign w_sum_l  = w_mic_l + w_term_t + w_term_f;
    assign w_sum_r  = w_mic_r + w_term_t + w_term_f;
    assign w_ovf_l  = (w_sum_l > SUM_MAX) || (w_sum_l < SUM_MIN);
    assign w_ovf_r  = (w_sum_r > SUM_MAX) || (w_sum_r < SUM_MIN);

    // Capture, mix and write-count datapath
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_left_in   <= '0;
            r_right_in  <= '0;
            r_title_snd <= 1'b0;
            r_fx_snd    <= 1'b0;
            r_title_act <= 1'b0;
            r_fx_act    <= 1'b0;
            r_mic       <= 1'b0;
            r_mute      <= 1'b0;
            r_gt        <= '0;
            r_gf        <= '0;
            r_left_out  <= '0;
            r_right_out <= '0;
            r_clip      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (r_state == CAPTURE) begin
                r_left_in   <= $signed(left_channel_audio_in);
                r_right_in  <= $signed(right_channel_audio_in);
                r_title_snd <= title_snd;
                r_fx_snd    <= fx_snd;
                r_title_act <= title_active;
                r_fx_act    <= fx_active;
                r_mic       <= mic_enable;
                r_mute      <= mute;
            end
            if (r_state == MIX) begin
                if (r_mute) begin
                    r_left_out  <= '0;
                    r_right_out <= '0;
                end else begin
                    r_left_out  <= sat32(w_sum_l);
                    r_right_out <= sat32(w_sum_r);
                    if (w_ovf_l || w_ovf_r) begin
                        r_clip <= 1'b1;
                    end
                end
                // Gains ramp one step per sample toward 0 or full scale.
                if (r_title_act && (r_gt < G_MAX)) begin
                    r_gt <= r_gt + 5'd1;
                end else if (!r_title_act && (r_gt != '0)) begin
                    r_gt <= r_gt - 5'd1;
                end
                if (r_fx_act && (r_gf < G_MAX)) begin
                    r_gf <= r_gf + 5'd1;
                end else if (!r_fx_act && (r_gf != '0)) begin
                    r_gf <= r_gf - 5'd1;
                end
            end
            if (w_write) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign read_audio_in           = w_read;
    assign write_audio_out         = w_write;
    assign left_channel_audio_out  = r_left_out;
    assign right_channel_audio_out = r_right_out;
    assign clip_flag               = r_clip;
    assign sample_count            = r_cnt;

endmodule

// File: tb/tb_audio_out_mixer.sv
// Self-checking bench for audio_out_mixer: directed fade, backpressure,
// saturation, mute and reset scenarios plus randomized samples, all checked
// against an arithmetic model of the mixing rules.
module tb_audio_out_mixer;

    localparam longint AMP_T = 60000000;
    localparam longint AMP_F = 80000000;

    logic        clk;
    logic        reset;
    logic        title_snd, title_active, fx_snd, fx_active;
    logic        mic_enable, mute;
    logic        avail, allowed;
    logic [31:0] left_in, right_in;
    logic        read_audio_in, write_audio_out;
    logic [31:0] left_out, right_out;
    logic        clip_flag;
    logic [15:0] sample_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_gt, m_gf, m_cnt;
    bit m_clip;

    audio_out_mixer #(
        .AMP_TITLE(32'd60000000),
        .AMP_FX   (32'd80000000)
    ) dut (
        .CLOCK_50               (clk),
        .reset                  (reset),
        .title_snd              (title_snd),
        .title_active           (title_active),
        .fx_snd                 (fx_snd),
        .fx_active              (fx_active),
        .mic_enable             (mic_enable),
        .mute                   (mute),
        .audio_in_available     (avail),
        .audio_out_allowed      (allowed),
        .left_channel_audio_in  (left_in),
        .right_channel_audio_in (right_in),
        .read_audio_in          (read_audio_in),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_out),
        .right_channel_audio_out(right_out),
        .clip_flag              (clip_flag),
        .sample_count           (sample_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit over(input longint s);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] clamp(input longint s);
        logic [63:0] v;
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        v = 64'(s);
        return v[31:0];
    endfunction

    // Expected outputs for the current inputs; advances gains and clip.
    task automatic predict(output logic [31:0] el, output logic [31:0] er);
        longint tt, tf, sl, sr;
        tt = (AMP_T * m_gt) / 16;
        tf = (AMP_F * m_gf) / 16;
        if (!title_snd) tt = -tt;
        if (!fx_snd) tf = -tf;
        sl = (mic_enable ? longint'($signed(left_in))  : 0) + tt + tf;
        sr = (mic_enable ? longint'($signed(right_in)) : 0) + tt + tf;
        if (mute) begin
            el = 32'h0;
            er = 32'h0;
        end else begin
            el = clamp(sl);
            er = clamp(sr);
            if (over(sl) || over(sr)) m_clip = 1'b1;
        end
        if (title_active) m_gt = (m_gt < 16) ? m_gt + 1 : 16;
        else              m_gt = (m_gt > 0)  ? m_gt - 1 : 0;
        if (fx_active)    m_gf = (m_gf < 16) ? m_gf + 1 : 16;
        else              m_gf = (m_gf > 0)  ? m_gf - 1 : 0;
    endtask

    // One full handshake with optional WRITE-state backpressure; called at a negedge.
    task automatic run_sample(input string tag, input int stall, output logic [31:0] got_l);
        logic [31:0] el, er;
        int n;
        predict(el, er);
        avail   = 1'b1;
        allowed = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!read_audio_in && n < 20);
        chk({tag, "_read"}, read_audio_in, 1);
        chk({tag, "_rw_excl"}, write_audio_out, 0);
        avail = 1'b0;
        @(negedge clk);
        chk({tag, "_mix_nowr"}, write_audio_out, 0);
        if (stall > 0) begin
            allowed = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                chk({tag, "_bp_hold"}, write_audio_out, 0);
            end
            allowed = 1'b1;
            #1;
        end else begin
            @(negedge clk);
        end
        chk({tag, "_write"}, write_audio_out, 1);
        chk({tag, "_wr_noread"}, read_audio_in, 0);
        chk({tag, "_left"}, left_out, el);
        chk({tag, "_right"}, right_out, er);
        chk({tag, "_clip"}, clip_flag, m_clip);
        got_l = left_out;
        @(negedge clk);
        chk({tag, "_one_pulse"}, write_audio_out, 0);
        m_cnt = (m_cnt + 1) & 16'hFFFF;
        chk({tag, "_count"}, sample_count, m_cnt);
    endtask

    task automatic set_voice(input logic ta, input logic ts, input logic fa, input logic fs,
                             input logic mic, input logic mu);
        title_active = ta; title_snd = ts; fx_active = fa; fx_snd = fs;
        mic_enable = mic; mute = mu;
    endtask

    initial begin
        logic [31:0] gl;
        longint      step;
        reset = 1'b1;
        avail = 1'b0;
        allowed = 1'b0;
        left_in = '0;
        right_in = '0;
        set_voice(0, 0, 0, 0, 0, 0);
        m_gt = 0; m_gf = 0; m_cnt = 0; m_clip = 0;

        repeat (3) @(negedge clk);
        avail = 1'b1;
        allowed = 1'b1;
        #1;
        chk("rst_read", read_audio_in, 0);
        chk("rst_write", write_audio_out, 0);
        chk("rst_left", left_out, 0);
        chk("rst_right", right_out, 0);
        chk("rst_clip", clip_flag, 0);
        chk("rst_count", sample_count, 0);
        avail = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_read", read_audio_in, 0);
        chk("post_rst_write", write_audio_out, 0);

        // Fade-in of the title voice: 3750000 per sample up to 60000000.
        set_voice(1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 18; k++) begin
            run_sample("fadein", 0, gl);
            step = 3750000 * ((k - 1 < 16) ? (k - 1) : 16);
            chk("fadein_const", gl, step);
        end

        // Fade-out back to zero on the 17th sample.
        set_voice(0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 18; k++) begin
            run_sample("fadeout", 0, gl);
            step = 60000000 - 3750000 * ((k - 1 < 16) ? (k - 1) : 16);
            chk("fadeout_const", gl, step);
        end

        // Backpressure held for 10 cycles in WRITE.
        run_sample("bp", 10, gl);

        // Bring both voices to full gain, then saturate each direction.
        set_voice(1, 1, 1, 1, 0, 0);
        for (int k = 0; k < 16; k++) run_sample("ramp", 0, gl);
        set_voice(1, 1, 1, 1, 1, 0);
        left_in = 32'h7FFF_0000;
        right_in = 32'h0;
        run_sample("sat_pos", 0, gl);
        chk("sat_pos_const", gl, 32'h7FFF_FFFF);
        chk("sat_pos_flag", clip_flag, 1);
        set_voice(1, 0, 1, 0, 1, 0);
        left_in = 32'h8001_0000;
        run_sample("sat_neg", 0, gl);
        chk("sat_neg_const", gl, 32'h8000_0000);

        // Mute at full gain: silence, clip flag untouched.
        set_voice(1, 1, 1, 1, 1, 1);
        left_in = 32'h7FFF_0000;
        run_sample("mute", 0, gl);
        chk("mute_const", gl, 0);

        // Randomized samples with random backpressure.
        for (int k = 0; k < 40; k++) begin
            title_active = 1'($urandom_range(0, 3) != 0);
            fx_active    = 1'($urandom_range(0, 2) != 0);
            title_snd    = 1'($urandom);
            fx_snd       = 1'($urandom);
            mic_enable   = 1'($urandom);
            mute         = 1'($urandom_range(0, 3) == 0);
            left_in      = $urandom;
            right_in     = $urandom;
            run_sample("rand", $urandom_range(0, 3), gl);
        end

        // Reset while held in WRITE.
        set_voice(1, 1, 1, 1, 0, 0);
        avail = 1'b1;
        allowed = 1'b1;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!read_audio_in && n < 20);
            chk("mid_read", read_audio_in, 1);
        end
        avail = 1'b0;
        allowed = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        allowed = 1'b1;
        #1;
        chk("mid_rst_write", write_audio_out, 0);
        chk("mid_rst_read", read_audio_in, 0);
        chk("mid_rst_left", left_out, 0);
        chk("mid_rst_right", right_out, 0);
        chk("mid_rst_count", sample_count, 0);
        chk("mid_rst_clip", clip_flag, 0);
        reset = 1'b0;
        m_gt = 0; m_gf = 0; m_cnt = 0; m_clip = 0;
        @(negedge clk);
        chk("mid_post_write", write_audio_out, 0);
        chk("mid_post_read", read_audio_in, 0);

        // Fresh sample after reset starts from zero gain.
        set_voice(1, 1, 1, 1, 1, 0);
        left_in = 32'd12345;
        right_in = 32'hFFFF_FF00;
        run_sample("after_rst", 0, gl);
        chk("after_rst_const", gl, 32'd12345);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/audio_out_mixer.md
AUDIO_OUT_MIXER -- requirements
Module: audio_out_mixer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of CLOCK_50.
REQ-002 Parameter AMP_TITLE, default 32'd60000000: full-scale magnitude of the title voice.
REQ-003 Parameter AMP_FX, default 32'd80000000: full-scale magnitude of the effect voice.
REQ-004 CLOCK_50  in  1  50 MHz system clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 title_snd  in  1  square-wave phase of the title tone generator (1 = positive half).
REQ-007 title_active  in  1  title voice note active.
REQ-008 fx_snd  in  1  square-wave phase of the effect (hit) tone generator.
REQ-009 fx_active  in  1  effect voice note active.
REQ-010 mic_enable  in  1  1 = add codec input samples to the mix.
REQ-011 mute  in  1  1 = force output samples to zero.
REQ-012 audio_in_available  in  1  codec input FIFO has a sample.
REQ-013 audio_out_allowed  in  1  codec output FIFO has space.
REQ-014 left_channel_audio_in, right_channel_audio_in  in  32 each  signed codec input samples.
REQ-015 read_audio_in  out  1  one-cycle pop strobe to the codec input FIFO.
REQ-016 write_audio_out  out  1  one-cycle push strobe to the codec output FIFO.
REQ-017 left_channel_audio_out, right_channel_audio_out  out  32 each  signed mixed samples.
REQ-018 clip_flag  out  1  sticky flag: a mixed sample saturated.
REQ-019 sample_count  out  16  count of samples written, wraps 65535 -> 0.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, CAPTURE, MIX, WRITE.
REQ-021 IDLE -> CAPTURE when audio_in_available and audio_out_allowed are both 1; otherwise the FSM SHALL stay in IDLE.
REQ-022 CAPTURE: read_audio_in = 1 for this cycle only; both input samples and title_snd, fx_snd, title_active, fx_active, mic_enable and mute SHALL be latched; next state MIX.
REQ-023 MIX: compute and register the outputs (REQ-025 to REQ-028); next state WRITE.
REQ-024 WRITE: if audio_out_allowed = 1, then write_audio_out = 1 for one cycle, sample_count increments, and the next state is IDLE; otherwise write_audio_out = 0 and the FSM SHALL stay in WRITE until audio_out_allowed = 1.
REQ-025 Voice gains g_t and g_f are 5-bit values in the range 0..16; in MIX, each gain SHALL increment by 1 if its latched active input is 1 and gain < 16, and decrement by 1 if the input is 0 and gain > 0.
REQ-026 The voice term SHALL be floor(AMP * g / 16) using the pre-update gain, with a 37-bit intermediate product; the term is positive if the latched snd = 1 and negated otherwise.
REQ-027 Per channel: sum = (mic_enable ? input sample : 0) + title term + fx term, computed in 34-bit signed arithmetic.
  - If sum > 2^31-1, the output SHALL be 32'h7FFFFFFF and clip_flag SHALL be set.
  - If sum < -2^31, the output SHALL be 32'h80000000 and clip_flag SHALL be set.
  - Otherwise the output SHALL be sum[31:0].
REQ-028 With mute latched at 1, both outputs SHALL be 0 and clip_flag SHALL NOT be set by that sample; gains, the write strobe and sample_count SHALL behave normally.
REQ-029 The outputs SHALL hold their values from MIX until the next MIX.
REQ-030 Latency: handshake seen in IDLE at cycle n -> read_audio_in at n+1 -> outputs valid at n+3 -> write_audio_out at n+3 at the earliest.
REQ-031 The block SHALL issue exactly one write_audio_out per read_audio_in, and SHALL never assert both strobes in the same cycle.

Reset
REQ-032 While reset = 1: state = IDLE; read_audio_in, write_audio_out, both outputs, clip_flag, sample_count, g_t and g_f SHALL all be 0.
REQ-033 Reset in any state SHALL abort the sample in progress; no strobe SHALL be asserted in the cycle after reset deasserts.

Verification
REQ-034 Fade-in: title_active = 1, title_snd = 1, mic_enable = 0, fx_active = 0, FIFO handshakes always true -> outputs on samples 1, 2, 3 are 0, 3750000, 7500000; from sample 17 onward the output is 60000000.
REQ-035 Fade-out: g_t = 16, then title_active = 0 -> the output decreases by 3750000 per sample and reaches 0 on sample 17; g_t stays 0 thereafter.
REQ-036 Backpressure: audio_out_allowed drops while in WRITE for 10 cycles -> write_audio_out stays 0, then pulses exactly once in the first cycle allowed returns; sample_count +1.
REQ-037 Saturation: g_t = g_f = 16, both snd = 1, mic_enable = 1, left input 32'h7FFF0000 -> left output 32'h7FFFFFFF and clip_flag = 1; repeat with both snd = 0 and left input 32'h80010000 -> left output 32'h80000000.
REQ-038 Mute: mute = 1 with voices at full gain -> outputs 0, clip_flag unchanged, sample_count still increments; sample_count at 65535 -> 0 after the next write.
REQ-039 Reset mid-sample: assert reset in WRITE -> in the next cycle the state is IDLE, write_audio_out = 0, outputs = 0, sample_count = 0 and clip_flag = 0.
